// File: rtl/secure_regfile.sv
// Register file with registered read ports, two write ports and a key-gated protected window.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module secure_regfile #(
    parameter int          XLEN          = 32,
    parameter int          NREGS         = 32,
    parameter int          PROT_BASE     = 28,
    parameter int          PROT_TOP      = 31,
    parameter logic [15:0] KEY           = 16'h0032,
    parameter int          UNLOCK_CYCLES = 64,
    parameter int          MAX_FAILS     = 3,
    localparam int         AW            = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rd_addr1,
    input  logic [AW-1:0]   rd_addr2,
    input  logic [AW-1:0]   st_addr,
    input  logic            wr_en_mem,
    input  logic [AW-1:0]   wr_addr_mem,
    input  logic [XLEN-1:0] wr_data_mem,
    input  logic            wr_en_alu,
    input  logic [AW-1:0]   wr_addr_alu,
    input  logic [XLEN-1:0] wr_data_alu,
    input  logic            unlock_req,
    input  logic [15:0]     unlock_key,
    input  logic            relock,
    output logic [XLEN-1:0] rd_data1,
    output logic [XLEN-1:0] rd_data2,
    output logic [XLEN-1:0] st_data,
    output logic            locked,
    output logic            lockout,
    output logic            violation,
    output logic [15:0]     key_access
);
    localparam int TW = $clog2(UNLOCK_CYCLES + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam logic [TW-1:0] UNLOCK_T = TW'(UNLOCK_CYCLES);
    localparam logic [FW-1:0] MAX_F    = FW'(MAX_FAILS);

    typedef enum logic [1:0] {
        S_LOCKED   = 2'd0,
        S_UNLOCKED = 2'd1,
        S_LOCKOUT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [FW-1:0]   fails_q, fails_d;
    logic [XLEN-1:0] regs [NREGS];
    logic [AW-1:0]   raddr [3];
    logic [XLEN-1:0] rnext [3];
    logic            unlocked, key_ok, alu_ok, mem_ok, viol_d;

    function automatic logic is_prot(input logic [AW-1:0] a);
        return (32'(a) >= PROT_BASE) && (32'(a) <= PROT_TOP);
    endfunction

    // An address is usable when it exists, is not x0, and is outside the window or unlocked.
    function automatic logic allowed(input logic [AW-1:0] a, input logic unl);
        return (32'(a) < NREGS) && (a != '0) && (!is_prot(a) || unl);
    endfunction

    assign unlocked   = (state_q == S_UNLOCKED);
    assign key_ok     = (unlock_key == KEY);
    assign locked     = (state_q != S_UNLOCKED);
    assign lockout    = (state_q == S_LOCKOUT);
    assign key_access = unlocked ? KEY : 16'h0000;

    // ALU wins a same-address collision, so the load write is suppressed.
    assign alu_ok = wr_en_alu && allowed(wr_addr_alu, unlocked);
    assign mem_ok = wr_en_mem && allowed(wr_addr_mem, unlocked)
                    && !(wr_en_alu && (wr_addr_alu == wr_addr_mem));

    assign viol_d = !unlocked && ((wr_en_alu && is_prot(wr_addr_alu))
                    || (wr_en_mem && is_prot(wr_addr_mem))
                    || is_prot(rd_addr1) || is_prot(rd_addr2) || is_prot(st_addr));

    assign raddr[0] = rd_addr1;
    assign raddr[1] = rd_addr2;
    assign raddr[2] = st_addr;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rnext[p] = '0;
            if (allowed(raddr[p], unlocked)) begin
                rnext[p] = regs[raddr[p]];
`ifdef REGFILE_BYPASS_EN
                if (alu_ok && (wr_addr_alu == raddr[p]))
                    rnext[p] = wr_data_alu;
                else if (mem_ok && (wr_addr_mem == raddr[p]))
                    rnext[p] = wr_data_mem;
`else
`endif
            end
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        fails_d = fails_q;
        case (state_q)
            S_LOCKED: begin
                if (!relock && unlock_req) begin
                    if (key_ok) begin
                        state_d = S_UNLOCKED;
                        timer_d = UNLOCK_T;
                        fails_d = '0;
                    end else begin
                        fails_d = fails_q + 1'b1;
                        if (fails_d >= MAX_F) state_d = S_LOCKOUT;
                    end
                end
            end
            S_UNLOCKED: begin
                if (relock) begin
                    state_d = S_LOCKED;
                    timer_d = '0;
                end else if (unlock_req && key_ok) begin
                    timer_d = UNLOCK_T;
                end else if (unlock_req) begin
                    state_d = S_LOCKED;
                    timer_d = '0;
                    fails_d = fails_q + 1'b1;
                    if (fails_d >= MAX_F) state_d = S_LOCKOUT;
                end else if (timer_q == TW'(1)) begin
                    state_d = S_LOCKED;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = S_LOCKOUT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_LOCKED;
            timer_q   <= '0;
            fails_q   <= '0;
            violation <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            fails_q   <= fails_d;
            violation <= viol_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            rd_data1 <= '0;
            rd_data2 <= '0;
            st_data  <= '0;
        end else begin
            if (alu_ok) regs[wr_addr_alu] <= wr_data_alu;
            if (mem_ok) regs[wr_addr_mem] <= wr_data_mem;
            rd_data1 <= rnext[0];
            rd_data2 <= rnext[1];
            st_data  <= rnext[2];
        end
    end
endmodule

// File: tb/tb_secure_regfile.sv
// Directed bench for secure_regfile: reset, x0, write priority, lock window, timer, lockout.
module tb_secure_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr1, rd_addr2, st_addr, wr_addr_mem, wr_addr_alu;
    logic        wr_en_mem, wr_en_alu, unlock_req, relock;
    logic [31:0] wr_data_mem, wr_data_alu;
    logic [15:0] unlock_key;
    logic [31:0] rd_data1, rd_data2, st_data;
    logic        locked, lockout, violation;
    logic [15:0] key_access;

    int n_vec = 0;
    int n_err = 0;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] EXP_SAME = 32'h0000_00A5;
`else
    localparam logic [31:0] EXP_SAME = 32'h0000_0001;
`endif

    always #5 clk = ~clk;

    secure_regfile dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .st_addr(st_addr),
        .wr_en_mem(wr_en_mem), .wr_addr_mem(wr_addr_mem), .wr_data_mem(wr_data_mem),
        .wr_en_alu(wr_en_alu), .wr_addr_alu(wr_addr_alu), .wr_data_alu(wr_data_alu),
        .unlock_req(unlock_req), .unlock_key(unlock_key), .relock(relock),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .st_data(st_data),
        .locked(locked), .lockout(lockout), .violation(violation), .key_access(key_access)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en_mem  = 1'b0;
        wr_en_alu  = 1'b0;
        unlock_req = 1'b0;
        relock     = 1'b0;
    endtask

    task automatic wr_alu(input logic [4:0] a, input logic [31:0] d);
        wr_en_alu = 1'b1; wr_addr_alu = a; wr_data_alu = d;
    endtask

    task automatic wr_mem(input logic [4:0] a, input logic [31:0] d);
        wr_en_mem = 1'b1; wr_addr_mem = a; wr_data_mem = d;
    endtask

    task automatic try_key(input logic [15:0] k);
        unlock_req = 1'b1; unlock_key = k;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rd_addr1 = '0; rd_addr2 = '0; st_addr = '0;
        wr_addr_mem = '0; wr_addr_alu = '0; wr_data_mem = '0; wr_data_alu = '0;
        unlock_key = '0;
        tick(); tick();
        chk("rst_rd1", rd_data1, 32'h0);
        chk("rst_rd2", rd_data2, 32'h0);
        chk("rst_st", st_data, 32'h0);
        chk("rst_locked", {31'b0, locked}, 32'h1);
        chk("rst_lockout", {31'b0, lockout}, 32'h0);
        chk("rst_violation", {31'b0, violation}, 32'h0);
        chk("rst_key_access", {16'b0, key_access}, 32'h0);
        rst = 1'b0;

        // r5 write then asynchronous reset while a write is pending
        wr_alu(5'd5, 32'h77); rd_addr1 = 5'd5;
        tick(); idle();
        tick();
        chk("r5_write", rd_data1, 32'h77);
        wr_alu(5'd5, 32'h99);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_rd1", rd_data1, 32'h0);
        chk("rst_async_locked", {31'b0, locked}, 32'h1);
        idle(); rst = 1'b0;
        tick();
        chk("r5_after_rst", rd_data1, 32'h0);

        // x0 hardwired, write-port priority
        wr_alu(5'd0, 32'hDEADBEEF); rd_addr1 = 5'd0;
        tick(); idle();
        tick();
        chk("x0_read", rd_data1, 32'h0);
        wr_mem(5'd7, 32'h11); wr_alu(5'd7, 32'h22);
        tick(); idle(); rd_addr2 = 5'd7;
        tick();
        chk("dual_write_alu_wins", rd_data2, 32'h22);
        wr_mem(5'd8, 32'h33); wr_alu(5'd7, 32'h44);
        tick(); idle(); st_addr = 5'd8;
        tick();
        chk("split_write_mem", st_data, 32'h33);
        chk("split_write_alu", rd_data2, 32'h44);

        // same-cycle read of a written register
        wr_alu(5'd9, 32'h01);
        tick(); wr_alu(5'd9, 32'hA5); rd_addr1 = 5'd9;
        tick(); idle();
        chk("same_cycle_read", rd_data1, EXP_SAME);
        tick();
        chk("next_cycle_read", rd_data1, 32'hA5);
        rd_addr1 = '0; rd_addr2 = '0; st_addr = '0;

        // locked window: write dropped, read zero, violation pulses
        wr_alu(5'd30, 32'h55);
        tick(); idle();
        chk("locked_wr_violation", {31'b0, violation}, 32'h1);
        rd_addr1 = 5'd30;
        tick();
        chk("locked_rd_zero", rd_data1, 32'h0);
        chk("locked_rd_violation", {31'b0, violation}, 32'h1);
        rd_addr1 = '0;
        tick();
        chk("violation_clears", {31'b0, violation}, 32'h0);

        // unlock and access the window
        try_key(16'h0032);
        tick(); idle();
        chk("unlock_locked", {31'b0, locked}, 32'h0);
        chk("unlock_key_access", {16'b0, key_access}, 32'h0032);
        wr_alu(5'd30, 32'h55);
        tick(); idle(); rd_addr1 = 5'd30;
        chk("unlocked_wr_no_violation", {31'b0, violation}, 32'h0);
        tick();
        chk("unlocked_r30", rd_data1, 32'h55);

        // relock beats a simultaneous correct unlock
        relock = 1'b1; try_key(16'h0032);
        tick(); idle();
        chk("relock_locked", {31'b0, locked}, 32'h1);
        chk("relock_key_access", {16'b0, key_access}, 32'h0);
        tick();
        chk("relock_r30_zero", rd_data1, 32'h0);
        rd_addr1 = '0;

        // unlock takes effect only after its own edge
        try_key(16'h0032); wr_alu(5'd30, 32'hAA);
        tick(); idle();
        chk("unlock_edge_violation", {31'b0, violation}, 32'h1);
        chk("unlock_edge_locked", {31'b0, locked}, 32'h0);
        rd_addr1 = 5'd30;
        tick();
        chk("unlock_edge_wr_dropped", rd_data1, 32'h55);

        // correct key reloads the timer; unlock lasts exactly UNLOCK_CYCLES
        try_key(16'h0032);
        tick(); idle(); rd_addr1 = '0;
        repeat (63) tick();
        chk("timer_cycle63", {31'b0, locked}, 32'h0);
        tick();
        chk("timer_cycle64", {31'b0, locked}, 32'h1);

        // three wrong keys -> permanent lockout
        try_key(16'h1234);
        tick(); idle();
        chk("fail1_lockout", {31'b0, lockout}, 32'h0);
        try_key(16'h1234);
        tick(); idle();
        chk("fail2_lockout", {31'b0, lockout}, 32'h0);
        try_key(16'h1234);
        tick(); idle();
        chk("fail3_lockout", {31'b0, lockout}, 32'h1);
        chk("fail3_locked", {31'b0, locked}, 32'h1);
        try_key(16'h0032);
        tick(); idle();
        chk("lockout_key_ignored", {31'b0, locked}, 32'h1);
        chk("lockout_key_access", {16'b0, key_access}, 32'h0);
        rst = 1'b1;
        #1;
        chk("lockout_rst_clears", {31'b0, lockout}, 32'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_locked", {31'b0, locked}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
